// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the 8085-style interrupt unit: source indices, default vectors, SIM bit positions.
package intr_ctrl_pkg;

  localparam int unsigned SRC_W = 5;
  localparam int unsigned VEC_W = 16;
  localparam int unsigned RIM_W = 8;

  localparam int unsigned INT_TRAP = 0;
  localparam int unsigned INT_R75  = 1;
  localparam int unsigned INT_R65  = 2;
  localparam int unsigned INT_R55  = 3;
  localparam int unsigned INT_INTR = 4;

  localparam logic [VEC_W-1:0] DEF_VEC_TRAP = 16'h0024;
  localparam logic [VEC_W-1:0] DEF_VEC_R75  = 16'h003C;
  localparam logic [VEC_W-1:0] DEF_VEC_R65  = 16'h0034;
  localparam logic [VEC_W-1:0] DEF_VEC_R55  = 16'h002C;

  localparam int unsigned SIM_SOD  = 7;
  localparam int unsigned SIM_SOE  = 6;
  localparam int unsigned SIM_R75R = 4;
  localparam int unsigned SIM_MSE  = 3;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [VEC_W-1:0] vec;
    logic             ext;
  } int_win_t;

endpackage

// File: rtl/intr_ctrl_sync_edge.sv
// Multi-flop synchroniser for one async pin, with a rising-edge pulse on the synced value.
module intr_ctrl_sync_edge #(
  parameter int unsigned SYNC_STG = 2
) (
  input  logic clk_,
  input  logic rst_,
  input  logic pin,
  output logic lvl,
  output logic rise_c
);

  logic [SYNC_STG-1:0] sync_q;
  logic                prev_q;

  always_ff @(posedge clk_ or negedge rst_) begin
    if (!rst_) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], pin};
      prev_q <= sync_q[SYNC_STG-1];
    end
  end

  assign lvl    = sync_q[SYNC_STG-1];
  assign rise_c = lvl & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// 8085-style interrupt unit: pin sync, masks/IE, boundary priority resolve, SIM/RIM.
// Optional serial I/O (SOD/SID) enabled by defining INTR_SERIAL_EN.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned       SYNC_STG = 2,
  parameter logic [VEC_W-1:0]  VEC_TRAP = DEF_VEC_TRAP,
  parameter logic [VEC_W-1:0]  VEC_R75  = DEF_VEC_R75,
  parameter logic [VEC_W-1:0]  VEC_R65  = DEF_VEC_R65,
  parameter logic [VEC_W-1:0]  VEC_R55  = DEF_VEC_R55
) (
  input  logic             clk_,
  input  logic             rst_,
  input  logic             pin_trap,
  input  logic             pin_r75,
  input  logic             pin_r65,
  input  logic             pin_r55,
  input  logic             pin_intr,
  input  logic             sim_wr,
  input  logic [7:0]       sim_dat,
  input  logic             ei_set,
  input  logic             di_clr,
  input  logic             int_smp,
  input  logic             int_ack,
  output logic             int_req,
  output logic             int_ext,
  output logic [SRC_W-1:0] int_src,
  output logic [VEC_W-1:0] int_vec,
  output logic             int_wake,
  output logic [RIM_W-1:0] rim_dat,
  output logic             pin_sod,
  input  logic             pin_sid
);

  logic trap_lvl, trap_rise_c, r75_lvl, r75_rise_c;
  logic r65_lvl, r65_rise_c, r55_lvl, r55_rise_c, intr_lvl, intr_rise_c;
  logic sid_lvl;

  intr_ctrl_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_trap (.clk_(clk_), .rst_(rst_), .pin(pin_trap), .lvl(trap_lvl), .rise_c(trap_rise_c));
  intr_ctrl_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_r75  (.clk_(clk_), .rst_(rst_), .pin(pin_r75),  .lvl(r75_lvl),  .rise_c(r75_rise_c));
  intr_ctrl_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_r65  (.clk_(clk_), .rst_(rst_), .pin(pin_r65),  .lvl(r65_lvl),  .rise_c(r65_rise_c));
  intr_ctrl_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_r55  (.clk_(clk_), .rst_(rst_), .pin(pin_r55),  .lvl(r55_lvl),  .rise_c(r55_rise_c));
  intr_ctrl_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_intr (.clk_(clk_), .rst_(rst_), .pin(pin_intr), .lvl(intr_lvl), .rise_c(intr_rise_c));

  logic unused_rise;
  assign unused_rise = &{1'b0, r75_lvl, r65_rise_c, r55_rise_c, intr_rise_c};

  logic       trap_l, r75_l, ie, ie_dly;
  logic [2:0] mask_q;  // {m75, m65, m55}

  logic trap_v, r75_v, r65_v, r55_v, intr_v, any_v, smp_take;
  int_win_t win;

  assign trap_v   = trap_l & trap_lvl;
  assign r75_v    = r75_l & ~mask_q[2] & ie;
  assign r65_v    = r65_lvl & ~mask_q[1] & ie;
  assign r55_v    = r55_lvl & ~mask_q[0] & ie;
  assign intr_v   = intr_lvl & ie;
  assign any_v    = trap_v | r75_v | r65_v | r55_v | intr_v;
  assign smp_take = int_smp & ~int_req & ~int_ack;

  // Fixed priority TRAP > 7.5 > 6.5 > 5.5 > INTR.
  always_comb begin
    win = '0;
    if (trap_v) begin
      win.src[INT_TRAP] = 1'b1;
      win.vec           = VEC_TRAP;
    end else if (r75_v) begin
      win.src[INT_R75] = 1'b1;
      win.vec          = VEC_R75;
    end else if (r65_v) begin
      win.src[INT_R65] = 1'b1;
      win.vec          = VEC_R65;
    end else if (r55_v) begin
      win.src[INT_R55] = 1'b1;
      win.vec          = VEC_R55;
    end else if (intr_v) begin
      win.src[INT_INTR] = 1'b1;
      win.ext           = 1'b1;
    end
  end

  always_ff @(posedge clk_ or negedge rst_) begin
    if (!rst_) begin
      int_req <= 1'b0;
      int_ext <= 1'b0;
      int_src <= '0;
      int_vec <= '0;
    end else if (int_ack) begin
      int_req <= 1'b0;
      int_ext <= 1'b0;
      int_src <= '0;
      int_vec <= '0;
    end else if (smp_take && any_v) begin
      int_req <= 1'b1;
      int_ext <= win.ext;
      int_src <= win.src;
      int_vec <= win.vec;
    end
  end

  // Pending latches: a fresh edge always beats any clear in the same clock.
  always_ff @(posedge clk_ or negedge rst_) begin
    if (!rst_) begin
      trap_l <= 1'b0;
      r75_l  <= 1'b0;
      mask_q <= 3'b111;
    end else begin
      if (trap_rise_c) trap_l <= 1'b1;
      else if (int_ack && int_src[INT_TRAP]) trap_l <= 1'b0;

      if (r75_rise_c) r75_l <= 1'b1;
      else if (sim_wr && sim_dat[SIM_R75R]) r75_l <= 1'b0;
      else if (int_ack && int_src[INT_R75]) r75_l <= 1'b0;

      if (sim_wr && sim_dat[SIM_MSE]) mask_q <= sim_dat[2:0];
    end
  end

  // EI takes effect only after the following boundary has been resolved.
  always_ff @(posedge clk_ or negedge rst_) begin
    if (!rst_) begin
      ie     <= 1'b0;
      ie_dly <= 1'b0;
    end else if (di_clr || int_ack) begin
      ie     <= 1'b0;
      ie_dly <= 1'b0;
    end else begin
      if (smp_take && ie_dly) begin
        ie     <= 1'b1;
        ie_dly <= 1'b0;
      end
      if (ei_set) ie_dly <= 1'b1;
    end
  end

  always_ff @(posedge clk_ or negedge rst_) begin
    if (!rst_) begin
      int_wake <= 1'b0;
      rim_dat  <= 8'h07;
    end else begin
      int_wake <= any_v;
      rim_dat  <= {sid_lvl, r75_l, r65_lvl, r55_lvl, ie, mask_q};
    end
  end

`ifdef INTR_SERIAL_EN
  logic sid_rise_c;
  intr_ctrl_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_sid (.clk_(clk_), .rst_(rst_), .pin(pin_sid), .lvl(sid_lvl), .rise_c(sid_rise_c));

  logic unused_sid;
  assign unused_sid = &{1'b0, sid_rise_c};

  always_ff @(posedge clk_ or negedge rst_) begin
    if (!rst_) pin_sod <= 1'b0;
    else if (sim_wr && sim_dat[SIM_SOE]) pin_sod <= sim_dat[SIM_SOD];
  end
`else
  assign pin_sod = 1'b0;
  assign sid_lvl = 1'b0;

  logic unused_sid;
  assign unused_sid = &{1'b0, pin_sid, sim_dat[7:6]};
`endif

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl (default SYNC_STG=2 and default vectors).
module tb_intr_ctrl;

  logic        clk_ = 1'b0;
  logic        rst_;
  logic        pin_trap, pin_r75, pin_r65, pin_r55, pin_intr;
  logic        sim_wr;
  logic [7:0]  sim_dat;
  logic        ei_set, di_clr, int_smp, int_ack;
  logic        int_req, int_ext, int_wake, pin_sod, pin_sid;
  logic [4:0]  int_src;
  logic [15:0] int_vec;
  logic [7:0]  rim_dat;

  int n_chk  = 0;
  int n_pass = 0;

  intr_ctrl dut (
    .clk_(clk_), .rst_(rst_),
    .pin_trap(pin_trap), .pin_r75(pin_r75), .pin_r65(pin_r65),
    .pin_r55(pin_r55), .pin_intr(pin_intr),
    .sim_wr(sim_wr), .sim_dat(sim_dat), .ei_set(ei_set), .di_clr(di_clr),
    .int_smp(int_smp), .int_ack(int_ack),
    .int_req(int_req), .int_ext(int_ext), .int_src(int_src), .int_vec(int_vec),
    .int_wake(int_wake), .rim_dat(rim_dat), .pin_sod(pin_sod), .pin_sid(pin_sid)
  );

  always #5 clk_ = ~clk_;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_);
      #1;
    end
  endtask

  task automatic smp();
    int_smp = 1'b1; tick(); int_smp = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic ei();
    ei_set = 1'b1; tick(); ei_set = 1'b0;
  endtask

  task automatic sim(input logic [7:0] d);
    sim_wr = 1'b1; sim_dat = d; tick(); sim_wr = 1'b0; sim_dat = 8'h00;
  endtask

  initial begin
    rst_ = 1'b0;
    {pin_trap, pin_r75, pin_r65, pin_r55, pin_intr, pin_sid} = '0;
    {sim_wr, ei_set, di_clr, int_smp, int_ack} = '0;
    sim_dat = 8'h00;
    tick(2);
    check("rst_req",  32'(int_req),  32'(0));
    check("rst_src",  32'(int_src),  32'(0));
    check("rst_vec",  32'(int_vec),  32'(0));
    check("rst_wake", 32'(int_wake), 32'(0));
    check("rst_rim",  32'(rim_dat),  32'(8'h07));
    check("rst_sod",  32'(pin_sod),  32'(0));
    rst_ = 1'b1;
    tick(2);

    // RST7.5 edge latched while masked
    pin_r75 = 1'b1; tick(3); pin_r75 = 1'b0; tick(4);
    smp();
    check("r75_masked_req", 32'(int_req), 32'(0));
    check("r75_masked_rim", 32'(rim_dat), 32'(8'h47));
    check("r75_masked_wake", 32'(int_wake), 32'(0));
    sim(8'h08);
    ei();
    smp();
    check("ei_boundary_req", 32'(int_req), 32'(0));
    tick();
    check("r75_wake", 32'(int_wake), 32'(1));
    smp();
    check("r75_req", 32'(int_req), 32'(1));
    check("r75_src", 32'(int_src), 32'(5'b00010));
    check("r75_vec", 32'(int_vec), 32'(16'h003C));
    check("r75_ext", 32'(int_ext), 32'(0));
    ack();
    check("ack_req", 32'(int_req), 32'(0));
    check("ack_vec", 32'(int_vec), 32'(0));
    tick();
    check("ack_rim", 32'(rim_dat), 32'(8'h00));

    // 6.5 beats 5.5; ack drops IE
    ei(); smp(); tick();
    check("ie_on_rim", 32'(rim_dat), 32'(8'h08));
    pin_r65 = 1'b1; pin_r55 = 1'b1; tick(4);
    smp();
    check("r65_src", 32'(int_src), 32'(5'b00100));
    check("r65_vec", 32'(int_vec), 32'(16'h0034));
    ack(); tick();
    check("r65_ack_rim", 32'(rim_dat), 32'(8'h30));
    smp();
    check("ie_off_req", 32'(int_req), 32'(0));
    pin_r65 = 1'b0; tick(4);
    ei(); smp();
    check("ei_none_req", 32'(int_req), 32'(0));
    smp();
    check("r55_src", 32'(int_src), 32'(5'b01000));
    check("r55_vec", 32'(int_vec), 32'(16'h002C));

    // Newer higher source waits while a request is outstanding
    pin_trap = 1'b1; tick(4);
    smp();
    check("frozen_src", 32'(int_src), 32'(5'b01000));
    ack();
    smp();
    check("trap_src", 32'(int_src), 32'(5'b00001));
    check("trap_vec", 32'(int_vec), 32'(16'h0024));
    ack();
    pin_trap = 1'b0; pin_r55 = 1'b0; tick(4);

    // TRAP edge seen but level gone at the boundary
    pin_trap = 1'b1; tick(4); pin_trap = 1'b0; tick(4);
    smp();
    check("trap_low_req", 32'(int_req), 32'(0));
    check("trap_low_wake", 32'(int_wake), 32'(0));
    pin_trap = 1'b1; tick(4);
    smp();
    check("trap_high_vec", 32'(int_vec), 32'(16'h0024));
    ack();
    pin_trap = 1'b0; tick(4);

    // RST7.5 edge and SIM R7.5 clear in the same clock: edge wins
    pin_r75 = 1'b1; tick(2);
    sim(8'h10);
    tick();
    check("r75_edge_wins", 32'(rim_dat), 32'(8'h40));
    pin_r75 = 1'b0;
    sim(8'h10); tick();
    check("r75_sim_clr", 32'(rim_dat), 32'(8'h00));
    tick(4);

    // TRAP over INTR, then INTR via INTA
    ei(); smp();
    pin_intr = 1'b1; pin_trap = 1'b1; tick(4);
    smp();
    check("trap_over_intr", 32'(int_src), 32'(5'b00001));
    ack();
    pin_trap = 1'b0; tick(4);
    ei(); smp(); smp();
    check("intr_ext", 32'(int_ext), 32'(1));
    check("intr_src", 32'(int_src), 32'(5'b10000));
    check("intr_vec", 32'(int_vec), 32'(0));
    ack();
    pin_intr = 1'b0; tick(4);

    // DI beats EI in the same clock
    ei_set = 1'b1; di_clr = 1'b1; tick(); ei_set = 1'b0; di_clr = 1'b0;
    smp(); tick();
    check("di_wins_rim", 32'(rim_dat), 32'(8'h00));

    // Reset in the middle of a request
    pin_r75 = 1'b1; tick(4); pin_r75 = 1'b0; tick(4);
    ei(); smp(); smp();
    check("pre_rst_req", 32'(int_req), 32'(1));
    rst_ = 1'b0; #1;
    check("mid_rst_req", 32'(int_req), 32'(0));
    check("mid_rst_src", 32'(int_src), 32'(0));
    check("mid_rst_rim", 32'(rim_dat), 32'(8'h07));
    tick(2);
    rst_ = 1'b1; tick(2);

`ifdef INTR_SERIAL_EN
    sim(8'hC0);
    check("sod_set", 32'(pin_sod), 32'(1));
    sim(8'h80);
    check("sod_hold", 32'(pin_sod), 32'(1));
    sim(8'h40);
    check("sod_clr", 32'(pin_sod), 32'(0));
    pin_sid = 1'b1; tick(4);
    check("sid_rim", 32'(rim_dat), 32'(8'h87));
`else
    sim(8'hC0);
    check("sod_tied", 32'(pin_sod), 32'(0));
    pin_sid = 1'b1; tick(4);
    check("sid_ignored", 32'(rim_dat), 32'(8'h07));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
